// File: rtl/sccb_pkg.sv
// sccb_pkg: transaction states and SCCB address bytes for the sccb_target responder
package sccb_pkg;
  typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WRD, ACK_WR, RDD, ACK_RD, IGNORE} sccb_state_t;
  localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
  localparam logic [7:0] SCCB_RD_ADDR = 8'h43;
endpackage

// File: rtl/sccb_if.sv
// sccb_if: fabric-side write strobe, busy status and register read port
interface sccb_if;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  modport master (output wr_valid, wr_addr, wr_data, busy, rd_data, input rd_addr);
  modport slave (input wr_valid, wr_addr, wr_data, busy, rd_data, output rd_addr);
endinterface

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: SCL/SDA synchronizers with SCL edge and START/STOP detection
module sccb_line_sync (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder with a 256x8 register file, ACK generation and two-phase reads
module sccb_target import sccb_pkg::*; #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         HOLD_CYCLES = 30
) (
  input  logic   clk_100MHz,
  input  logic   rst_n,
  input  logic   cmos_scl,
  inout  wire    cmos_sda,
  sccb_if.master fab
);
  localparam logic [15:0] HOLD = 16'(HOLD_CYCLES);
  sccb_state_t st, st_nx;
  logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic        rise, last, rw, drv, pend, sda_low;
  logic [2:0]  cnt;
  logic [7:0]  sh, ptr, byte_val;
  logic [15:0] tmr;
  logic [7:0]  regfile [256];

  sccb_line_sync u_sync (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .scl(cmos_scl), .sda(cmos_sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det), .sda_s(sda_s)
  );

  assign cmos_sda    = sda_low ? 1'b0 : 1'bz;
  assign fab.rd_data = regfile[fab.rd_addr];
  assign byte_val    = {sh[6:0], sda_s};
  assign rise        = scl_rise & ~start_det & ~stop_det;
  assign last        = rise & (cnt == 3'd7);

  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nx;

  always_comb begin
    st_nx = st;
    drv   = (st inside {ACK_DEV, ACK_SUB, ACK_WR}) | (st == RDD & ~sh[7]);
    if (start_det) st_nx = DEV;
    else if (stop_det) st_nx = IDLE;
    else if (rise)
      case (st)
        DEV:             st_nx = last ? (byte_val[7:1] == DEV_ADDR ? ACK_DEV : IGNORE) : DEV;
        ACK_DEV:         st_nx = rw ? RDD : SUB;
        SUB:             st_nx = last ? ACK_SUB : SUB;
        ACK_SUB, ACK_WR: st_nx = WRD;
        WRD:             st_nx = last ? ACK_WR : WRD;
        RDD:             st_nx = last ? ACK_RD : RDD;
        ACK_RD:          st_nx = sda_s ? IGNORE : RDD;
        default:         st_nx = st;
      endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      cnt          <= '0;
      sh           <= '0;
      ptr          <= '0;
      rw           <= 1'b0;
      fab.wr_valid <= 1'b0;
      fab.wr_addr  <= '0;
      fab.wr_data  <= '0;
      fab.busy     <= 1'b0;
    end else begin
      fab.wr_valid <= 1'b0;
      fab.busy     <= stop_det ? 1'b0 : fab.busy | (st == ACK_DEV);
      if (start_det | stop_det) cnt <= '0;
      else if (rise) begin
        if (st inside {DEV, SUB, WRD, RDD}) cnt <= cnt + 3'd1;
        sh <= st == RDD ? {sh[6:0], 1'b0} : byte_val;
        if (last && st == DEV) rw <= sda_s;
        if (last && st == SUB) ptr <= byte_val;
        if (last && st == WRD) begin
          fab.wr_valid <= 1'b1;
          fab.wr_addr  <= ptr;
          fab.wr_data  <= byte_val;
        end
        if (st == ACK_DEV && rw) sh <= regfile[ptr];
        if (st == ACK_WR) ptr <= ptr + 8'd1;
        if (st == ACK_RD && !sda_s) begin
          ptr <= ptr + 8'd1;
          sh  <= regfile[ptr + 8'd1];
        end
      end
    end

  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 256; i++) regfile[i] <= '0;
    else if (last && st == WRD) regfile[ptr] <= byte_val;

  // SDA target is chosen at the SCL fall and applied only once the hold time has elapsed
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      tmr     <= '0;
      pend    <= 1'b0;
      sda_low <= 1'b0;
    end else if (start_det | stop_det) begin
      tmr     <= '0;
      sda_low <= 1'b0;
    end else if (scl_fall) begin
      tmr  <= HOLD;
      pend <= drv;
    end else if (tmr != '0) begin
      tmr <= tmr - 16'd1;
      if (tmr == 16'd1) sda_low <= pend;
    end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB master driving directed write/read vectors into sccb_target
module tb_sccb_target;
  import sccb_pkg::*;
  localparam int HOLD = 30;
  localparam int Q    = 40;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] dat;
    logic       ack;
  } vec_t;

  logic clk_100MHz = 1'b0;
  logic rst_n      = 1'b0;
  logic scl        = 1'b1;
  logic m_low      = 1'b0;
  wire  sda;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  sccb_if bus ();
  sccb_target #(.DEV_ADDR(7'h21), .HOLD_CYCLES(HOLD)) dut (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .cmos_scl(scl), .cmos_sda(sda), .fab(bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int         n_cmp = 0, n_bad = 0, cyc = 0, fall_cyc = 0, wr_cnt = 0, dut_chg = 0, hold_bad = 0;
  logic [7:0] wr_a = 8'h00, wr_d = 8'h00;
  logic       prev_sda = 1'b1, prev_m = 1'b0;
  logic [7:0] mdl [256];

  // SDA changes while the master line is steady come from the DUT; measure their lag from SCL fall
  always @(negedge clk_100MHz) begin
    cyc++;
    if (bus.wr_valid === 1'b1) begin
      wr_cnt++;
      wr_a = bus.wr_addr;
      wr_d = bus.wr_data;
    end
    if (sda !== prev_sda && m_low === prev_m) begin
      dut_chg++;
      if (cyc - fall_cyc < HOLD) hold_bad++;
    end
    prev_sda = sda;
    prev_m   = m_low;
  end

  initial begin
    repeat (150000) @(posedge clk_100MHz);
    $display("FAIL watchdog: run did not complete within 150000 cycles");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic clk_bit(input logic low, output logic s);
    tick(Q); m_low = low;
    tick(Q); scl = 1'b1;
    tick(Q); s = sda;
    tick(Q); scl = 1'b0; fall_cyc = cyc;
  endtask

  task automatic start_c();
    if (!scl) begin
      tick(Q); m_low = 1'b0;
      tick(Q); scl = 1'b1;
    end
    tick(Q); m_low = 1'b1;
    tick(Q); scl = 1'b0; fall_cyc = cyc;
  endtask

  task automatic stop_c();
    tick(Q); m_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); m_low = 1'b0;
    tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
    clk_bit(1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b0, s);
      v = {v[6:0], s};
    end
    clk_bit(ack_m, s);
  endtask

  initial begin
    vec_t       v [7];
    logic       a;
    logic [7:0] r;
    int         w0, c0;
    v[0] = '{8'h42, 8'h12, 8'h80, 1'b1};
    v[1] = '{8'h42, 8'h8C, 8'h5A, 1'b1};
    v[2] = '{8'h42, 8'h3A, 8'hC3, 1'b1};
    v[3] = '{8'h60, 8'h12, 8'hFF, 1'b0};
    v[4] = '{8'h44, 8'h00, 8'h77, 1'b0};
    v[5] = '{8'h42, 8'h00, 8'h01, 1'b1};
    v[6] = '{8'h42, 8'hFE, 8'hA5, 1'b1};
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    bus.rd_addr = 8'h12;
    tick(5);
    check("rst_sda", sda, 1'b1);
    check("rst_wr_valid", bus.wr_valid, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 8'h00);
    check("rst_wr_data", bus.wr_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rd_data", bus.rd_data, 8'h00);
    rst_n = 1'b1;
    tick(10);

    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      c0 = dut_chg;
      start_c();
      send_byte(v[i].dev, a); check("dev_ack", a, v[i].ack);
      check("busy_in_txn", bus.busy, v[i].ack);
      send_byte(v[i].sub, a); check("sub_ack", a, v[i].ack);
      send_byte(v[i].dat, a); check("dat_ack", a, v[i].ack);
      stop_c();
      if (v[i].ack) mdl[v[i].sub] = v[i].dat;
      check("wr_pulses", wr_cnt - w0, v[i].ack ? 1 : 0);
      if (v[i].ack) begin
        check("wr_addr", wr_a, v[i].sub);
        check("wr_data", wr_d, v[i].dat);
      end else check("sda_undriven", dut_chg - c0, 0);
      check("busy_after_stop", bus.busy, 1'b0);
      bus.rd_addr = v[i].sub;
      #1 check("rd_data", bus.rd_data, mdl[v[i].sub]);
    end

    w0 = wr_cnt;
    start_c();
    send_byte(8'h42, a); check("wrap_dev_ack", a, 1'b1);
    send_byte(8'hFF, a); check("wrap_sub_ack", a, 1'b1);
    send_byte(8'h11, a); check("wrap_d0_ack", a, 1'b1);
    send_byte(8'h22, a); check("wrap_d1_ack", a, 1'b1);
    stop_c();
    mdl[8'hFF] = 8'h11;
    mdl[8'h00] = 8'h22;
    check("wrap_pulses", wr_cnt - w0, 2);
    check("wrap_last_addr", wr_a, 8'h00);
    check("wrap_last_data", wr_d, 8'h22);
    bus.rd_addr = 8'hFF;
    #1 check("wrap_rd_ff", bus.rd_data, mdl[8'hFF]);
    bus.rd_addr = 8'h00;
    #1 check("wrap_rd_00", bus.rd_data, mdl[8'h00]);

    w0 = wr_cnt;
    start_c();
    send_byte(8'h42, a); send_byte(8'h8C, a); check("rd_sub_ack", a, 1'b1);
    stop_c();
    start_c();
    send_byte(SCCB_RD_ADDR, a); check("rd_dev_ack", a, 1'b1);
    check("rd_busy", bus.busy, 1'b1);
    read_byte(1'b0, r); check("rd_byte_8c", r, mdl[8'h8C]);
    read_byte(1'b0, r); check("ignore_released", r, 8'hFF);
    stop_c();
    check("rd_no_writes", wr_cnt - w0, 0);
    check("rd_busy_after_stop", bus.busy, 1'b0);

    start_c();
    send_byte(8'h42, a); send_byte(8'h3A, a);
    start_c();
    send_byte(SCCB_RD_ADDR, a); check("sr_dev_ack", a, 1'b1);
    read_byte(1'b0, r); check("sr_byte_3a", r, mdl[8'h3A]);
    stop_c();

    start_c();
    send_byte(8'h42, a); send_byte(8'hFE, a);
    stop_c();
    start_c();
    send_byte(SCCB_RD_ADDR, a);
    read_byte(1'b1, r); check("inc_byte_fe", r, mdl[8'hFE]);
    read_byte(1'b0, r); check("inc_byte_ff", r, mdl[8'hFF]);
    stop_c();

    check("hold_lag_violations", hold_bad, 0);
    check("dut_sda_activity", dut_chg > 0, 1'b1);

    start_c();
    send_byte(8'h42, a);
    for (int i = 7; i >= 0; i--) clk_bit(~r[i] & 1'b0 | ~(8'h50 >> i) & 1'b1, a);
    tick(Q); m_low = 1'b0;
    tick(Q);
    check("ack_held_low", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda", sda, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    bus.rd_addr = 8'h12;
    #1 check("rst_mid_regfile", bus.rd_data, 8'h00);
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    scl = 1'b1;
    tick(Q);
    rst_n = 1'b1;
    tick(Q);
    scl = 1'b0;
    fall_cyc = cyc;
    send_byte(8'h42, a); check("idle_no_ack", a, 1'b0);
    w0 = wr_cnt;
    start_c();
    send_byte(8'h42, a); check("post_rst_dev_ack", a, 1'b1);
    send_byte(8'h12, a); check("post_rst_sub_ack", a, 1'b1);
    send_byte(8'h99, a); check("post_rst_dat_ack", a, 1'b1);
    stop_c();
    mdl[8'h12] = 8'h99;
    check("post_rst_pulses", wr_cnt - w0, 1);
    #1 check("post_rst_rd", bus.rd_data, mdl[8'h12]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
